// File: rtl/mem_access_unit.sv
// mem_access_unit: in-order request FIFO feeding a fixed-latency load/store engine over internal word memory
module mem_access_unit #(
   parameter int DEPTH       = 4,
   parameter int MEM_LATENCY = 3,
   parameter int MEM_WORDS   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_load,
   input  logic        req_byte,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_store_data,
   input  logic [5:0]  req_rd_tag,
   input  logic [5:0]  req_rob_index,
   output logic        resp_valid,
   output logic        resp_is_load,
   output logic [5:0]  resp_rd_tag,
   output logic [5:0]  resp_rob_index,
   output logic [31:0] resp_load_value,
   output logic        busy
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
   typedef struct packed {
      logic          is_load;
      logic          is_byte;
      logic [AW+1:0] addr;
      logic [31:0]   data;
      logic [5:0]    tag;
      logic [5:0]    rob;
   } entry_t;
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t        state, state_nx;
   entry_t        fifo [DEPTH];
   entry_t        op;
   logic [PW-1:0] head, tail;
   logic [PW:0]   count;
   logic [LW-1:0] lat;
   logic [31:0]   mem [MEM_WORDS] = '{default: '0};
   logic          push, pop, fire, unused;
   logic [31:0]   word, wr_word;
   logic [7:0]    lane_b;
   logic [4:0]    sh;
   assign req_ready = count < (PW+1)'(DEPTH);
   assign push      = req_valid && req_ready;
   assign pop       = state == IDLE && count != '0;
   assign fire      = state == ACCESS && lat == '0;
   assign busy      = count != '0 || state != IDLE;
   assign unused    = ^req_addr[31:AW+2];
   // lane arithmetic works on the word currently addressed by the op in flight
   assign word    = mem[op.addr[AW+1:2]];
   assign sh      = {op.addr[1:0], 3'b000};
   assign lane_b  = 8'(word >> sh);
   assign wr_word = op.is_byte ? (word & ~(32'hFF << sh)) | (32'(op.data[7:0]) << sh) : op.data;
   always_comb begin
      state_nx = pop ? ACCESS : fire ? IDLE : state;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         lat             <= '0;
         resp_valid      <= 1'b0;
         resp_is_load    <= 1'b0;
         resp_rd_tag     <= '0;
         resp_rob_index  <= '0;
         resp_load_value <= '0;
      end else begin
         state      <= state_nx;
         head       <= pop ? head + 1'b1 : head;
         tail       <= push ? tail + 1'b1 : tail;
         count      <= count + (PW+1)'(push) - (PW+1)'(pop);
         lat        <= pop ? LW'(MEM_LATENCY - 1) : (state == ACCESS && lat != '0) ? lat - 1'b1 : lat;
         resp_valid <= fire;
         if (fire) begin
            resp_is_load    <= op.is_load;
            resp_rd_tag     <= op.is_load ? op.tag : '0;
            resp_rob_index  <= op.rob;
            resp_load_value <= !op.is_load ? '0 : op.is_byte ? {{24{lane_b[7]}}, lane_b} : word;
         end
      end
   end
   // storage without reset: memory survives rst, and an aborted op never fires
   always_ff @(posedge clk) begin
      if (push) fifo[tail] <= '{req_is_load, req_byte, req_addr[AW+1:0], req_store_data, req_rd_tag, req_rob_index};
      if (pop) op <= fifo[head];
      if (fire && !op.is_load) mem[op.addr[AW+1:2]] <= wr_word;
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries (power of two).
REQ-002 Parameter MEM_LATENCY, default 3, cycles spent in ACCESS per request (>=1).
REQ-003 Parameter MEM_WORDS, default 1024, 32-bit words of internal data memory.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  LSQ offers a memory operation this cycle.
REQ-007 req_ready  out  1  FIFO can accept; equals (count < DEPTH), independent of same-cycle pop.
REQ-008 req_is_load  in  1  1=load, 0=store.
REQ-009 req_byte  in  1  1=byte access, 0=word access.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_store_data  in  32  store data; byte store uses bits [7:0].
REQ-012 req_rd_tag  in  6  load destination tag; don't-care for stores.
REQ-013 req_rob_index  in  6  ROB index of the operation.
REQ-014 resp_valid  out  1  one-cycle completion pulse.
REQ-015 resp_is_load  out  1  completed op was a load.
REQ-016 resp_rd_tag  out  6  tag of completed load.
REQ-017 resp_rob_index  out  6  ROB index of completed op.
REQ-018 resp_load_value  out  32  load result; 0 for stores.
REQ-019 busy  out  1  high when FIFO non-empty or state != IDLE.

Function
REQ-020 Push on rising edge when req_valid && req_ready; all req_* fields captured in one entry; req_valid while !req_ready is ignored (no entry, no side effect).
REQ-021 FIFO strictly in-order; wrap-around pointers modulo DEPTH; simultaneous push and pop leaves count unchanged.
REQ-022 FSM states IDLE, ACCESS. IDLE->ACCESS on edge with count>0: head popped into op register, latency counter loaded with MEM_LATENCY-1.
REQ-023 ACCESS: counter decrements each edge; on edge with counter==0 the memory operation executes, response registers load, resp_valid=1, state->IDLE.
REQ-024 resp_valid drops on the next edge unless a new response is produced; in IDLE a pop may occur on the same edge resp_valid drops.
REQ-025 Latency: request pushed at edge E0 on empty idle unit -> popped at E1 -> resp_valid high in the cycle after edge E1+MEM_LATENCY; sustained throughput one op per MEM_LATENCY+1 cycles.
REQ-026 Word index = req_addr[11:2] (low log2(MEM_WORDS) bits above [1:0]); higher address bits ignored; word accesses ignore addr[1:0].
REQ-027 Little-endian: byte lane = addr[1:0], lane k occupies bits [8k+7:8k].
REQ-028 Word load returns full word; byte load returns selected lane sign-extended to 32 bits.
REQ-029 Word store writes 32 bits; byte store writes only the selected lane, other lanes unchanged.
REQ-030 Store completes with resp_is_load=0, resp_load_value=0, resp_rd_tag=0.
REQ-031 A load behind a same-address store in the FIFO returns the stored value (ordering guarantee).
REQ-032 Memory contents initialized to zero at time zero only.

Reset
REQ-033 rst high clears asynchronously: FIFO count, head and tail pointers to 0, state IDLE, counter 0, resp_valid 0, resp_is_load 0, resp_rd_tag 0, resp_rob_index 0, resp_load_value 0; req_ready=1, busy=0 thereafter.
REQ-034 Reset does not clear memory contents.
REQ-035 Reset during ACCESS aborts in-flight op: no memory write, no response; queued entries discarded.

Verification
REQ-036 Store word addr 0x10 data 0xDEADBEEF rob 5, then load word addr 0x10 tag 9 rob 6 -> responses in order: (store, rob 5), then (load, tag 9, rob 6, value 0xDEADBEEF).
REQ-037 After REQ-036, store byte addr 0x12 data 0x80, load word 0x10 -> 0xDE80BEEF; load byte 0x12 -> 0xFFFFFF80; load byte 0x13 -> 0xFFFFFFDE.
REQ-038 Single load pushed at edge E0 on idle unit, MEM_LATENCY=3 -> resp_valid high exactly one cycle, after edge E4.
REQ-039 Push 5 requests back-to-back with DEPTH=4 while unit busy -> req_ready low when count=4, stalled request accepted only after pop, 5 responses in push order, none lost or duplicated.
REQ-040 Store word 0x20 data 0x12345678 reaches ACCESS, assert rst with counter=1 -> no response, busy=0 after reset; subsequent load 0x20 returns 0x00000000.
